// File: rtl/i2c_write_queue.sv
// rtl/i2c_write_queue.sv - command FIFO feeding (addr,data) writes to the I2C master one at a time
// Optional WAIT_BUSY abort timer: define I2C_QUEUE_TIMEOUT_EN.
module i2c_write_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
`ifdef I2C_QUEUE_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  input  logic [6:0]       push_addr,
  input  logic [7:0]       push_data,
  output logic             push_ready,
  input  logic             m_ready,
  output logic             m_start,
  output logic [6:0]       m_addr,
  output logic [7:0]       m_data,
  output logic             busy,
  output logic [PTR_W:0]   level,
  output logic             cmd_done,
  output logic             overflow,
  output logic             timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  state_t           state_q, state_d;
  logic [14:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   level_q, level_d;
  logic             full, push_acc, pop, done_d;
  logic             m_start_q, cmd_done_q, overflow_q;
  logic [6:0]       m_addr_q;
  logic [7:0]       m_data_q;

`ifdef I2C_QUEUE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_d;
  logic             timeout_err_q;
`endif

  // A same-cycle pop does not relieve a full FIFO.
  assign full       = (level_q == (PTR_W+1)'(DEPTH));
  assign push_ready = !full && !reset;
  assign push_acc   = push_valid && push_ready;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    done_d  = 1'b0;
`ifdef I2C_QUEUE_TIMEOUT_EN
    tmo_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (level_q != '0 && m_ready) begin
          pop     = 1'b1;
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!m_ready) begin
          state_d = S_WAIT_DONE;
        end
`ifdef I2C_QUEUE_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      S_WAIT_DONE: begin
        if (m_ready) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({push_acc, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= {push_addr, push_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      m_start_q  <= 1'b0;
      m_addr_q   <= '0;
      m_data_q   <= '0;
      cmd_done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      m_start_q  <= pop;
      cmd_done_q <= done_d;
      if (push_acc) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q             <= rd_ptr_q + 1'b1;
        {m_addr_q, m_data_q} <= mem_q[rd_ptr_q];
      end
      if (push_valid && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef I2C_QUEUE_TIMEOUT_EN
  // Counts m_ready-high cycles spent in WAIT_BUSY since the last start pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (pop) begin
        cnt_q <= '0;
      end else if (state_q == S_WAIT_BUSY && m_ready) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (tmo_d) begin
        timeout_err_q <= 1'b1;
      end
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign m_start  = m_start_q;
  assign m_addr   = m_addr_q;
  assign m_data   = m_data_q;
  assign busy     = (state_q != S_IDLE);
  assign level    = level_q;
  assign cmd_done = cmd_done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_i2c_write_queue.sv
// tb/tb_i2c_write_queue.sv - directed self-checking bench for i2c_write_queue
module tb_i2c_write_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       push_valid;
  logic [6:0] push_addr;
  logic [7:0] push_data;
  logic       push_ready;
  logic       m_ready;
  logic       m_start;
  logic [6:0] m_addr;
  logic [7:0] m_data;
  logic       busy;
  logic [3:0] level;
  logic       cmd_done;
  logic       overflow;
  logic       timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  i2c_write_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .push_valid  (push_valid),
    .push_addr   (push_addr),
    .push_data   (push_data),
    .push_ready  (push_ready),
    .m_ready     (m_ready),
    .m_start     (m_start),
    .m_addr      (m_addr),
    .m_data      (m_data),
    .busy        (busy),
    .level       (level),
    .cmd_done    (cmd_done),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [6:0] a, input logic [7:0] d);
    push_valid = 1'b1;
    push_addr  = a;
    push_data  = d;
    tick();
    push_valid = 1'b0;
  endtask

  // Master model: accept one command, stay busy for 'low' cycles, then finish.
  task automatic serve(input logic [6:0] ea, input logic [7:0] ed, input int low);
    bit seen;
    seen    = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (m_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("start_seen", 32'(seen), 1);
    if (seen) begin
      check("m_addr", 32'(m_addr), 32'(ea));
      check("m_data", 32'(m_data), 32'(ed));
      tick();
      check("start_one_cycle", 32'(m_start), 0);
      m_ready = 1'b0;
      repeat (low) tick();
      check("busy_in_flight", 32'(busy), 1);
      check("no_reissue", 32'(m_start), 0);
      m_ready = 1'b1;
      seen    = 1'b0;
      for (int k = 0; k < 5; k++) begin
        tick();
        if (cmd_done === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      check("cmd_done_seen", 32'(seen), 1);
      check("idle_after_done", 32'(busy), 0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    push_valid = 1'b0;
    push_addr  = '0;
    push_data  = '0;
    m_ready    = 1'b1;
    tick();
    tick();
    check("rst_push_ready", 32'(push_ready), 0);
    check("rst_level", 32'(level), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_m_start", 32'(m_start), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    reset = 1'b0;
    tick();
    check("push_ready_after_rst", 32'(push_ready), 1);

    // 1: single command, start one cycle after acceptance
    push(7'h50, 8'hAA);
    check("t1_level1", 32'(level), 1);
    check("t1_no_start_yet", 32'(m_start), 0);
    tick();
    check("t1_start", 32'(m_start), 1);
    check("t1_addr", 32'(m_addr), 32'h50);
    check("t1_data", 32'(m_data), 32'hAA);
    check("t1_level0", 32'(level), 0);
    serve(7'h50, 8'hAA, 3);
    tick();
    check("t1_done_pulse", 32'(cmd_done), 0);

    // 2: three queued commands, long busy phase each, order preserved
    m_ready = 1'b0;
    push(7'h21, 8'h01);
    push(7'h22, 8'h02);
    push(7'h23, 8'h03);
    check("t2_level3", 32'(level), 3);
    serve(7'h21, 8'h01, 20);
    serve(7'h22, 8'h02, 20);
    serve(7'h23, 8'h03, 20);
    check("t2_level0", 32'(level), 0);

    // 3: fill to DEPTH, 9th dropped, stored entries drain intact
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("t3_push_ready", 32'(push_ready), (i < 8) ? 1 : 0);
      push(7'(8'h10 + i), 8'(8'hC0 + i));
    end
    check("t3_level8", 32'(level), 8);
    check("t3_overflow", 32'(overflow), 1);
    for (int i = 0; i < 8; i++) serve(7'(8'h10 + i), 8'(8'hC0 + i), 2);
    check("t3_level0", 32'(level), 0);
    check("t3_overflow_sticky", 32'(overflow), 1);

    // 4: reset during WAIT_DONE with four entries still queued
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(7'(8'h30 + i), 8'(i));
    m_ready = 1'b1;
    tick();
    check("t4_start", 32'(m_start), 1);
    m_ready = 1'b0;
    tick();
    tick();
    check("t4_level4", 32'(level), 4);
    check("t4_busy", 32'(busy), 1);
    reset   = 1'b1;
    m_ready = 1'b1;
    tick();
    check("t4_level0", 32'(level), 0);
    check("t4_busy0", 32'(busy), 0);
    check("t4_start0", 32'(m_start), 0);
    check("t4_done0", 32'(cmd_done), 0);
    check("t4_ovf_clr", 32'(overflow), 0);
    check("t4_push_ready_rst", 32'(push_ready), 0);
    reset = 1'b0;
    tick();
    check("t4_no_done", 32'(cmd_done), 0);
    check("t4_idle", 32'(busy), 0);

    // 5: simultaneous push and pop at level 3, then wrap pointers to 2*DEPTH
    m_ready = 1'b0;
    push(7'h41, 8'h11);
    push(7'h42, 8'h12);
    push(7'h43, 8'h13);
    m_ready = 1'b1;
    push(7'h44, 8'h14);
    check("t5_level_same", 32'(level), 3);
    serve(7'h41, 8'h11, 2);
    serve(7'h42, 8'h12, 2);
    serve(7'h43, 8'h13, 2);
    serve(7'h44, 8'h14, 2);
    for (int b = 0; b < 2; b++) begin
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) push(7'(8'h60 + 6*b + i), 8'(8'h80 + 6*b + i));
      for (int i = 0; i < 6; i++) serve(7'(8'h60 + 6*b + i), 8'(8'h80 + 6*b + i), 1);
    end
    check("t5_level0", 32'(level), 0);

    // 6: master never drops ready after start
    m_ready = 1'b0;
    push(7'h71, 8'h5A);
    push(7'h72, 8'hA5);
    m_ready = 1'b1;
    tick();
    check("t6_start", 32'(m_start), 1);
    repeat (14) tick();
    check("t6_busy_early", 32'(busy), 1);
    check("t6_tmo_early", 32'(timeout_err), 0);
`ifdef I2C_QUEUE_TIMEOUT_EN
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (timeout_err === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      check("t6_timeout_err", 32'(seen), 1);
      check("t6_busy_cleared", 32'(busy), 0);
      check("t6_no_done", 32'(cmd_done), 0);
    end
    serve(7'h72, 8'hA5, 2);
`else
    repeat (16) tick();
    check("t6_busy_stays", 32'(busy), 1);
    check("t6_tmo_tied0", 32'(timeout_err), 0);
    m_ready = 1'b0;
    tick();
    m_ready = 1'b1;
    tick();
    check("t6_done_late", 32'(cmd_done), 1);
    serve(7'h72, 8'hA5, 2);
`endif
    check("t6_level0", 32'(level), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
